multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences a shared-memory, multicycle MIPS datapath: PC, IR, A/B, ALUOut, MDR, one ALU, one memory port.
- Implements the same opcode set and ALUOp encoding as the single-cycle decoder.
  - ALUOp encoding: 00 add, 01 sub, 10 or, 11 R-type funct.
- Owns the memory request/ack handshake, a per-access timeout watchdog and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, maximum cycles of mem_ack_i low in a wait state before entering ERROR; 0 disables the watchdog.
- CNT_W, 32, width of retired_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active high.
- op_i  in  6  IR[31:26]; valid from DECODE onward.
- mem_ack_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory request; held high until ack.
- IorD_o  out  1  0 = PC address, 1 = ALUOut address.
- MemRead_o  out  1  memory read.
- MemWrite_o  out  1  memory write.
- IRWrite_o  out  1  load IR.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero.
- PCSource_o  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUSrcA_o  out  1  0 = PC, 1 = A.
- ALUSrcB_o  out  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- ALUOp_o  out  2  00 add, 01 sub, 10 or, 11 R-type.
- RegDst_o  out  1  1 = rd, 0 = rt.
- RegWrite_o  out  1  register file write.
- MemtoReg_o  out  1  1 = MDR, 0 = ALUOut.
- illegal_o  out  1  one-cycle pulse on an undefined opcode.
- bus_err_o  out  1  sticky watchdog error.
- retired_o  out  CNT_W  retired-instruction count, wraps.
- state_o  out  4  current state.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JUMP 10, ERROR 15. Other codes go to FETCH.
- Reset (rst_i high at an edge):
  - state = FETCH, op_q = 0, wait counter = 0, retired_o = 0, bus_err_o = 0.
  - Aborts any wait state; the first cycle after reset drives a fetch.
- Any output not listed for a state is 0.
- FETCH: mem_req, MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite = mem_ack_i (Mealy on ack).
  - On ack go to DECODE, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Latch op_q <= op_i. Next state by op_i:
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x00 -> EXEC_R.
  - 0x08 or 0x0D -> EXEC_I.
  - 0x04 -> BRANCH.
  - 0x02 -> JUMP.
  - Any other opcode -> FETCH with illegal_o=1 this cycle; not retired.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if op_q=0x23, else MEM_WRITE.
- MEM_READ: mem_req, MemRead, IorD=1. On ack go to MEM_WB.
- MEM_WB: RegWrite, MemtoReg=1, RegDst=0. Retire, then FETCH.
- MEM_WRITE: mem_req, MemWrite, IorD=1. On ack retire, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11. Go to ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp = 10 if op_q=0x0D, else 00. Go to ALU_WB.
- ALU_WB: RegWrite, MemtoReg=0, RegDst = (op_q==0x00). Retire, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Retire, then FETCH.
- JUMP: PCWrite, PCSource=10. Retire, then FETCH.
- Latency with zero-wait memory (acks in the first cycle of each memory state):
  - lw 5 cycles; R-type, addi, ori and sw 4 cycles; beq and j 3 cycles.
- Watchdog (FETCH, MEM_READ, MEM_WRITE):
  - The wait counter increments each cycle mem_ack_i=0 and clears on any state change.
  - When the counter reaches TIMEOUT with ack still low, the next state is ERROR.
  - An ack in that same cycle wins.
- ERROR: all controls 0, bus_err_o=1. Held until reset.
- retired_o: +1 on each retire cycle; wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then R-type (op 0x00) with immediate ack -> states 0,1,6,8,0; RegWrite=1 and RegDst=1 in state 8; retired_o=1.
- lw (0x23), ack delayed 3 cycles in FETCH and 2 in MEM_READ -> mem_req held throughout; IRWrite pulses only on the ack cycle; MemtoReg=1 in MEM_WB; 10 cycles total.
- ori (0x0D) then addi (0x08) -> ALUOp=10 then 00 in EXEC_I; sw (0x2B) -> MemWrite with IorD=1; retired_o=3.
- Opcode 0x3F -> illegal_o high for one cycle in DECODE, next state FETCH, retired_o unchanged.
- TIMEOUT=4, ack never asserted in MEM_READ -> ERROR after the 4th low cycle, bus_err_o=1 sticky; rst_i pulse -> FETCH, bus_err_o=0.
- CNT_W=2, five beq instructions -> retired_o sequence 1,2,3,0,1; PCWriteCond=1 and ALUOp=01 in each BRANCH.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : Moore FSM sequencing a shared-memory multicycle MIPS
//                      datapath, with memory handshake watchdog and retire count
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       op_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             PCWrite_o,
   output logic             PCWriteCond_o,
   output logic [1:0]       PCSource_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic             RegDst_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             illegal_o,
   output logic             bus_err_o,
   output logic [CNT_W-1:0] retired_o,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ERROR     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Counter only ever holds 0..TIMEOUT-1; one spare bit of headroom is harmless.
   localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nx;
   logic [5:0]        op_q;
   logic [WC_W-1:0]   wait_cnt;
   logic              wait_st;
   logic              timeout_hit;
   logic              retire;

   assign wait_st = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);

   generate
      if (TIMEOUT > 0) begin : g_wdog
         assign timeout_hit = wait_st && !mem_ack_i &&
                              (wait_cnt == WC_W'(TIMEOUT - 1));
      end else begin : g_no_wdog
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= FETCH;
         op_q      <= 6'h00;
         wait_cnt  <= '0;
         retired_o <= '0;
      end else begin
         state <= state_nx;
         if (state == DECODE)
            op_q <= op_i;
         if (state_nx != state)
            wait_cnt <= '0;
         else if (wait_st && !mem_ack_i && (TIMEOUT > 0))
            wait_cnt <= wait_cnt + WC_W'(1);
         if (retire)
            retired_o <= retired_o + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx      = state;
      mem_req_o     = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      PCSource_o    = 2'b00;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALUOp_o       = 2'b00;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      MemtoReg_o    = 1'b0;
      illegal_o     = 1'b0;
      bus_err_o     = 1'b0;
      retire        = 1'b0;

      case (state)
         FETCH: begin
            mem_req_o = 1'b1;
            MemRead_o = 1'b1;
            ALUSrcB_o = 2'b01;
            IRWrite_o = mem_ack_i;
            PCWrite_o = mem_ack_i;
            // An ack arriving on the timeout cycle still completes the fetch.
            if (mem_ack_i)
               state_nx = DECODE;
            else if (timeout_hit)
               state_nx = ERROR;
         end
         DECODE: begin
            ALUSrcB_o = 2'b11;
            case (op_i)
               OP_LW, OP_SW:    state_nx = MEM_ADDR;
               OP_RTYPE:        state_nx = EXEC_R;
               OP_ADDI, OP_ORI: state_nx = EXEC_I;
               OP_BEQ:          state_nx = BRANCH;
               OP_J:            state_nx = JUMP;
               default: begin
                  illegal_o = 1'b1;
                  state_nx  = FETCH;
               end
            endcase
         end
         MEM_ADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            state_nx  = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            mem_req_o = 1'b1;
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
            if (mem_ack_i)
               state_nx = MEM_WB;
            else if (timeout_hit)
               state_nx = ERROR;
         end
         MEM_WB: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = 1'b1;
            retire     = 1'b1;
            state_nx   = FETCH;
         end
         MEM_WRITE: begin
            mem_req_o  = 1'b1;
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
            if (mem_ack_i) begin
               retire   = 1'b1;
               state_nx = FETCH;
            end else if (timeout_hit) begin
               state_nx = ERROR;
            end
         end
         EXEC_R: begin
            ALUSrcA_o = 1'b1;
            ALUOp_o   = 2'b11;
            state_nx  = ALU_WB;
         end
         EXEC_I: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALUOp_o   = (op_q == OP_ORI) ? 2'b10 : 2'b00;
            state_nx  = ALU_WB;
         end
         ALU_WB: begin
            RegWrite_o = 1'b1;
            RegDst_o   = (op_q == OP_RTYPE);
            retire     = 1'b1;
            state_nx   = FETCH;
         end
         BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUOp_o       = 2'b01;
            PCWriteCond_o = 1'b1;
            PCSource_o    = 2'b01;
            retire        = 1'b1;
            state_nx      = FETCH;
         end
         JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = 2'b10;
            retire     = 1'b1;
            state_nx   = FETCH;
         end
         ERROR: begin
            bus_err_o = 1'b1;
         end
         default: state_nx = FETCH;
      endcase
   end

   assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : instruction-level scoreboard bench for multicycle_control
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [5:0] op_i = 6'h00;
   logic       mem_ack_i = 1'b0;
   logic       mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o;
   logic       PCWriteCond_o, ALUSrcA_o, RegDst_o, RegWrite_o, MemtoReg_o;
   logic       illegal_o, bus_err_o;
   logic [1:0] PCSource_o, ALUSrcB_o, ALUOp_o, retired_o;
   logic [3:0] state_o;

   multicycle_control #(.TIMEOUT(TO), .CNT_W(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ack_i(mem_ack_i),
      .mem_req_o(mem_req_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
      .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
      .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
      .illegal_o(illegal_o), .bus_err_o(bus_err_o), .retired_o(retired_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        chk;
      logic [3:0]  st;
      logic [18:0] ctl;
      logic [1:0]  ret;
   } exp_t;

   exp_t  expq[$];
   string nameq[$];
   int    checks = 0;
   int    errors = 0;
   int    mret   = 0;

   wire [18:0] got_ctl = {mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                          PCWrite_o, PCWriteCond_o, PCSource_o, ALUSrcA_o,
                          ALUSrcB_o, ALUOp_o, RegDst_o, RegWrite_o, MemtoReg_o,
                          illegal_o, bus_err_o};

   function automatic logic [18:0] ctl(
      input logic req, iord, mrd, mwr, irw, pcw, pcwc,
      input logic [1:0] pcsrc, input logic srca, input logic [1:0] srcb,
      input logic [1:0] aluop, input logic regdst, regwr, m2r, ill, berr);
      return {req, iord, mrd, mwr, irw, pcw, pcwc, pcsrc, srca, srcb, aluop,
              regdst, regwr, m2r, ill, berr};
   endfunction

   // Expected per-phase control words, derived from the datapath role of each step.
   function automatic logic [18:0] c_fetch(input logic ack);
      return ctl(1,0,1,0,ack,ack,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
   endfunction
   function automatic logic [18:0] c_decode(input logic ill);
      return ctl(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,ill,0);
   endfunction
   localparam logic [18:0] C_MADDR = 19'(ctl(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0));
   localparam logic [18:0] C_MREAD = 19'(ctl(1,1,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0));
   localparam logic [18:0] C_MWB   = 19'(ctl(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0,0));
   localparam logic [18:0] C_MWR   = 19'(ctl(1,1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0));
   localparam logic [18:0] C_EXR   = 19'(ctl(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b11,0,0,0,0,0));
   localparam logic [18:0] C_BEQ   = 19'(ctl(0,0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0,0));
   localparam logic [18:0] C_JMP   = 19'(ctl(0,0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0,0));
   localparam logic [18:0] C_ERR   = 19'(ctl(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,1));

   // Monitor: compares every presented cycle against the oldest queued expectation.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e  = expq.pop_front();
            nm = nameq.pop_front();
            if (e.chk) begin
               checks++;
               if (state_o !== e.st || got_ctl !== e.ctl || retired_o !== e.ret) begin
                  errors++;
                  $display("FAIL %s @%0t: got state=%0d ctl=%05h retired=%0d, expected state=%0d ctl=%05h retired=%0d",
                           nm, $time, state_o, got_ctl, retired_o, e.st, e.ctl, e.ret);
               end
            end
         end
      end
   end

   task automatic step(input logic [5:0] op, input logic ack, input logic rst,
                       input logic [3:0] st, input logic [18:0] c, input string nm);
      logic [1:0] r;
      r         = 2'(mret);
      op_i      = op;
      mem_ack_i = ack;
      rst_i     = rst;
      expq.push_back('{chk: 1'b1, st: st, ctl: c, ret: r});
      nameq.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] rop();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // mode 0: normal; 1: memory never acks (watchdog); 2: reset during memory wait.
   task automatic mem_phase(input logic [3:0] st, input logic [18:0] c, input int w,
                            input int mode, output bit aborted);
      aborted = 0;
      if (mode == 1) begin
         for (int i = 0; i < TO; i++) step(rop(), 0, 0, st, c, "wdog_wait");
         for (int i = 0; i < 3; i++) step(rop(), rbit(), 0, 4'd15, C_ERR, "error_sticky");
         step(rop(), 0, 1, 4'd15, C_ERR, "error_reset");
         mret = 0;
         aborted = 1;
      end else if (mode == 2) begin
         for (int i = 0; i < 2; i++) step(rop(), 0, 0, st, c, "abort_wait");
         step(rop(), 0, 1, st, c, "abort_reset");
         mret = 0;
         aborted = 1;
      end else begin
         for (int i = 0; i < w; i++) step(rop(), 0, 0, st, c, "mem_wait");
         step(rop(), 1, 0, st, c, "mem_ack");
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int mode);
      bit ab;
      for (int i = 0; i < fw; i++) step(rop(), 0, 0, 4'd0, c_fetch(0), "fetch_wait");
      step(rop(), 1, 0, 4'd0, c_fetch(1), "fetch_ack");
      case (op)
         6'h23, 6'h2B: begin
            step(op, rbit(), 0, 4'd1, c_decode(0), "decode_mem");
            step(rop(), rbit(), 0, 4'd2, C_MADDR, "mem_addr");
            if (op == 6'h23) begin
               mem_phase(4'd3, C_MREAD, mw, mode, ab);
               if (!ab) begin
                  step(rop(), rbit(), 0, 4'd4, C_MWB, "mem_wb");
                  mret++;
               end
            end else begin
               mem_phase(4'd5, C_MWR, mw, mode, ab);
               if (!ab) mret++;
            end
         end
         6'h00: begin
            step(op, rbit(), 0, 4'd1, c_decode(0), "decode_r");
            step(rop(), rbit(), 0, 4'd6, C_EXR, "exec_r");
            step(rop(), rbit(), 0, 4'd8,
                 ctl(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0,0), "alu_wb_r");
            mret++;
         end
         6'h08, 6'h0D: begin
            step(op, rbit(), 0, 4'd1, c_decode(0), "decode_i");
            step(rop(), rbit(), 0, 4'd7,
                 ctl(0,0,0,0,0,0,0,2'b00,1,2'b10,(op == 6'h0D) ? 2'b10 : 2'b00,0,0,0,0,0),
                 "exec_i");
            step(rop(), rbit(), 0, 4'd8,
                 ctl(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,0,0,0), "alu_wb_i");
            mret++;
         end
         6'h04: begin
            step(op, rbit(), 0, 4'd1, c_decode(0), "decode_beq");
            step(rop(), rbit(), 0, 4'd9, C_BEQ, "branch");
            mret++;
         end
         6'h02: begin
            step(op, rbit(), 0, 4'd1, c_decode(0), "decode_j");
            step(rop(), rbit(), 0, 4'd10, C_JMP, "jump");
            mret++;
         end
         default: step(op, rbit(), 0, 4'd1, c_decode(1), "decode_illegal");
      endcase
   endtask

   logic [5:0] pool [10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h04, 6'h02,
                             6'h3F, 6'h01, 6'h24};

   initial begin
      int t;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      step(6'h00, 0, 1, 4'd0, c_fetch(0), "reset_state");
      mret = 0;

      run_instr(6'h00, 0, 0, 0);           // R-type, zero wait
      run_instr(6'h23, 3, 2, 0);           // lw with delayed acks
      run_instr(6'h0D, 0, 0, 0);
      run_instr(6'h08, 1, 0, 0);
      run_instr(6'h2B, 0, 3, 0);           // ack on the last legal cycle wins
      run_instr(6'h3F, 0, 0, 0);           // illegal, not retired
      for (int i = 0; i < 5; i++) run_instr(6'h04, 0, 0, 0);
      run_instr(6'h02, 3, 0, 0);
      run_instr(6'h23, 0, 0, 1);           // watchdog into ERROR, then reset
      run_instr(6'h00, 0, 0, 0);
      run_instr(6'h2B, 1, 0, 2);           // reset aborts a memory wait
      run_instr(6'h04, 0, 0, 0);

      for (int i = 0; i < 150; i++)
         run_instr(pool[$urandom_range(0, 9)], $urandom_range(0, TO - 1),
                   $urandom_range(0, TO - 1), 0);

      t = 0;
      while (expq.size() > 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
